eth_tx_arb: RTL and testbench
=============================

// Module: eth_tx_arb
// PURPOSE
//  Round-robin arbiter sharing one eth_tx application interface between REQ_N
//  requesters. Grants one packet at a time, relays the early-valid/ready header
//  handshake, then passes the granted stream unmodified until last or cancel.
//  Watchdog cancels stalled packets; one-cycle gap enforced between packets.
// PARAMETERS
//  REQ_N      2    number of requesters (>=2)
//  DATA_W     16   app data width; KEEP_W=DATA_W/8, LEN_W=$clog2(KEEP_W+1)
//  PKT_LEN_W  16   packet length width
//  UDP_CS_W   16   UDP checksum width
//  WDOG_MAX   64   max consecutive DATA cycles with req valid low before forced cancel
// PORTS
//  clk              in   1                 clock
//  nreset           in   1                 synchronous reset, active low
//  req_early_v_i    in   REQ_N             per-requester packet request
//  req_ready_v_o    out  REQ_N             per-requester header accepted
//  req_cancel_i     in   REQ_N             per-requester abort
//  req_valid_i      in   REQ_N             per-requester data valid
//  req_last_i       in   REQ_N             per-requester last beat
//  req_data_i       in   REQ_N*DATA_W      flattened data, requester r at [r*DATA_W+:DATA_W]
//  req_len_i        in   REQ_N*LEN_W       flattened byte-valid
//  req_pkt_len_i    in   REQ_N*PKT_LEN_W   flattened packet length
//  req_cs_i         in   REQ_N*UDP_CS_W    flattened UDP checksum
//  tx_early_v_o     out  1                 to eth_tx app_early_v_i
//  tx_ready_v_i     in   1                 from eth_tx app_ready_v_o
//  tx_cancel_o      out  1                 to eth_tx app_cancel_i
//  tx_valid_o / tx_last_o  out 1           to eth_tx app_valid_i / app_last_i
//  tx_data_o / tx_len_o    out DATA_W/LEN_W to eth_tx app_data_i / app_len_i
//  tx_pkt_len_o / tx_cs_o  out PKT_LEN_W/UDP_CS_W to eth_tx
//  grant_o          out  $clog2(REQ_N)     current/last granted index
//  busy_o           out  1                 state != IDLE
//  wdog_err_o       out  1                 1-cycle pulse on watchdog cancel
// BEHAVIOUR
//  States IDLE, HEAD, DATA, GAP. Reset: IDLE, rr pointer=REQ_N-1 (req 0 wins
//   first), grant_o=0, wdog counter 0; all tx_* outputs, req_ready_v_o, busy_o,
//   wdog_err_o = 0 in the first cycle after reset. Reset mid-packet aborts silently.
//  IDLE: any req_early_v_i -> winner = first requester set scanning from ptr+1
//   with wrap; register grant, ptr<=winner, -> HEAD. Latency: request cycle N,
//   tx_early_v_o high cycle N+1.
//  HEAD: tx_early_v_o=req_early_v_i[g]; tx_pkt_len_o/tx_cs_o muxed from g.
//   tx_ready_v_i&tx_early_v_o -> req_ready_v_o[g]=1 same cycle (comb), -> DATA.
//   req_early_v_i[g] low before ready -> IDLE, no cancel. Non-granted ready=0.
//  DATA: tx_valid/last/data/len/cancel = requester g's signals (comb mux);
//   pkt_len/cs keep muxing g. valid&last -> GAP. cancel -> tx_cancel_o=1, -> GAP.
//   cancel and last same cycle: forwarded together, cancel precedence, -> GAP.
//  Watchdog: counter clears on req valid, increments otherwise in DATA; reaching
//   WDOG_MAX -> tx_cancel_o=1, wdog_err_o=1 that cycle, -> GAP. Saturating, cleared
//   on entry to DATA.
//  GAP: one cycle, all tx strobes 0 -> IDLE (requests ignored here).
//  Outside HEAD/DATA: tx_data/len/pkt_len/cs forced 0; strobes 0.
// TESTING
//  req0 early_v, tx_ready 2 cycles later, 19B pkt (9 full beats + 1B last) ->
//   tx_early_v_o cycle+1, req_ready_v_o[0] with ready, 10 beats forwarded bit-exact.
//  req0,req1 early_v same cycle after reset -> grant 0 first, then gap, grant 1;
//   repeat -> alternates 0,1,0,1.
//  req1 cancel at beat 3 -> tx_cancel_o=1 that cycle, GAP, IDLE; next grant req0.
//  req0 granted, valid low 64 cycles in DATA -> tx_cancel_o & wdog_err_o 1 cycle, GAP.
//  req0 drops early_v while in HEAD -> IDLE, no tx_cancel_o, req1 served next.
//  nreset low during DATA beat 4 -> next cycle all tx strobes 0, busy_o=0, grant_o=0.

Source files
------------

// File: rtl/eth_tx_arb.sv
// Round-robin arbiter sharing one eth_tx application interface between REQ_N requesters.
// One packet is granted at a time: header handshake relay, then stream passthrough until last/cancel.
module eth_tx_arb #(
    parameter int REQ_N     = 2,
    parameter int DATA_W    = 16,
    parameter int PKT_LEN_W = 16,
    parameter int UDP_CS_W  = 16,
    parameter int WDOG_MAX  = 64,
    localparam int KEEP_W   = DATA_W / 8,
    localparam int LEN_W    = $clog2(KEEP_W + 1),
    localparam int GNT_W    = $clog2(REQ_N)
) (
    input  logic                         clk,
    input  logic                         nreset,
    input  logic [REQ_N-1:0]             req_early_v_i,
    output logic [REQ_N-1:0]             req_ready_v_o,
    input  logic [REQ_N-1:0]             req_cancel_i,
    input  logic [REQ_N-1:0]             req_valid_i,
    input  logic [REQ_N-1:0]             req_last_i,
    input  logic [REQ_N*DATA_W-1:0]      req_data_i,
    input  logic [REQ_N*LEN_W-1:0]       req_len_i,
    input  logic [REQ_N*PKT_LEN_W-1:0]   req_pkt_len_i,
    input  logic [REQ_N*UDP_CS_W-1:0]    req_cs_i,
    output logic                         tx_early_v_o,
    input  logic                         tx_ready_v_i,
    output logic                         tx_cancel_o,
    output logic                         tx_valid_o,
    output logic                         tx_last_o,
    output logic [DATA_W-1:0]            tx_data_o,
    output logic [LEN_W-1:0]             tx_len_o,
    output logic [PKT_LEN_W-1:0]         tx_pkt_len_o,
    output logic [UDP_CS_W-1:0]          tx_cs_o,
    output logic [GNT_W-1:0]             grant_o,
    output logic                         busy_o,
    output logic                         wdog_err_o
);
    localparam int WDOG_W = $clog2(WDOG_MAX + 1);

    typedef enum logic [1:0] {IDLE, HEAD, DATA, GAP} state_t;

    state_t             state_q, state_d;
    logic [GNT_W-1:0]   grant_q, grant_d;
    logic [GNT_W-1:0]   ptr_q, ptr_d;
    logic [GNT_W-1:0]   winner;
    logic [WDOG_W-1:0]  wdog_q, wdog_d;
    logic               any_req;
    logic               wdog_hit;

    logic                 g_early, g_cancel, g_valid, g_last;
    logic [DATA_W-1:0]    g_data;
    logic [LEN_W-1:0]     g_len;
    logic [PKT_LEN_W-1:0] g_pkt_len;
    logic [UDP_CS_W-1:0]  g_cs;

    assign g_early   = req_early_v_i[grant_q];
    assign g_cancel  = req_cancel_i[grant_q];
    assign g_valid   = req_valid_i[grant_q];
    assign g_last    = req_last_i[grant_q];
    assign g_data    = req_data_i[int'(grant_q)*DATA_W +: DATA_W];
    assign g_len     = req_len_i[int'(grant_q)*LEN_W +: LEN_W];
    assign g_pkt_len = req_pkt_len_i[int'(grant_q)*PKT_LEN_W +: PKT_LEN_W];
    assign g_cs      = req_cs_i[int'(grant_q)*UDP_CS_W +: UDP_CS_W];

    assign any_req  = |req_early_v_i;
    // Fires on the WDOG_MAX-th consecutive idle beat of the granted stream.
    assign wdog_hit = (state_q == DATA) && !g_valid && (wdog_q == WDOG_W'(WDOG_MAX - 1));

    // Scan from the farthest offset down so the nearest requester after ptr wins.
    always_comb begin
        winner = ptr_q;
        for (int i = REQ_N; i >= 1; i--) begin
            if (req_early_v_i[GNT_W'((int'(ptr_q) + i) % REQ_N)]) begin
                winner = GNT_W'((int'(ptr_q) + i) % REQ_N);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= GNT_W'(REQ_N - 1);
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            wdog_q  <= wdog_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        wdog_d  = wdog_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = winner;
                    ptr_d   = winner;
                    state_d = HEAD;
                end
            end
            HEAD: begin
                if (!g_early) begin
                    state_d = IDLE;
                end else if (tx_ready_v_i) begin
                    state_d = DATA;
                    wdog_d  = '0;
                end
            end
            DATA: begin
                if (g_valid) begin
                    wdog_d = '0;
                end else if (wdog_q != WDOG_W'(WDOG_MAX)) begin
                    wdog_d = wdog_q + 1'b1;
                end
                if (g_cancel || (g_valid && g_last) || wdog_hit) begin
                    state_d = GAP;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_v_o = '0;
        tx_early_v_o  = 1'b0;
        tx_cancel_o   = 1'b0;
        tx_valid_o    = 1'b0;
        tx_last_o     = 1'b0;
        tx_data_o     = '0;
        tx_len_o      = '0;
        tx_pkt_len_o  = '0;
        tx_cs_o       = '0;
        wdog_err_o    = 1'b0;
        case (state_q)
            HEAD: begin
                tx_early_v_o           = g_early;
                tx_pkt_len_o           = g_pkt_len;
                tx_cs_o                = g_cs;
                req_ready_v_o[grant_q] = g_early & tx_ready_v_i;
            end
            DATA: begin
                tx_valid_o   = g_valid;
                tx_last_o    = g_last;
                tx_data_o    = g_data;
                tx_len_o     = g_len;
                tx_cancel_o  = g_cancel | wdog_hit;
                wdog_err_o   = wdog_hit;
                tx_pkt_len_o = g_pkt_len;
                tx_cs_o      = g_cs;
            end
            default: ;
        endcase
    end

    assign busy_o  = (state_q != IDLE);
    assign grant_o = grant_q;

endmodule

// File: tb/tb_eth_tx_arb.sv
// Directed bench for eth_tx_arb: beats pushed to a scoreboard when driven,
// popped and compared whenever the arbiter forwards a valid beat.
module tb_eth_tx_arb;
    localparam int REQ_N     = 2;
    localparam int DATA_W    = 16;
    localparam int PKT_LEN_W = 16;
    localparam int UDP_CS_W  = 16;
    localparam int WDOG_MAX  = 64;
    localparam int LEN_W     = $clog2(DATA_W / 8 + 1);
    localparam int GNT_W     = $clog2(REQ_N);

    logic                       clk = 1'b0;
    logic                       nreset;
    logic [REQ_N-1:0]           req_early_v, req_cancel, req_valid, req_last;
    logic [REQ_N*DATA_W-1:0]    req_data;
    logic [REQ_N*LEN_W-1:0]     req_len;
    logic [REQ_N*PKT_LEN_W-1:0] req_pkt_len;
    logic [REQ_N*UDP_CS_W-1:0]  req_cs;
    logic                       tx_ready_v;
    logic [REQ_N-1:0]           req_ready_v_o;
    logic                       tx_early_v_o, tx_cancel_o, tx_valid_o, tx_last_o;
    logic [DATA_W-1:0]          tx_data_o;
    logic [LEN_W-1:0]           tx_len_o;
    logic [PKT_LEN_W-1:0]       tx_pkt_len_o;
    logic [UDP_CS_W-1:0]        tx_cs_o;
    logic [GNT_W-1:0]           grant_o;
    logic                       busy_o, wdog_err_o;

    always #5 clk = ~clk;

    eth_tx_arb #(
        .REQ_N(REQ_N), .DATA_W(DATA_W), .PKT_LEN_W(PKT_LEN_W),
        .UDP_CS_W(UDP_CS_W), .WDOG_MAX(WDOG_MAX)
    ) dut (
        .clk(clk), .nreset(nreset),
        .req_early_v_i(req_early_v), .req_ready_v_o(req_ready_v_o),
        .req_cancel_i(req_cancel), .req_valid_i(req_valid), .req_last_i(req_last),
        .req_data_i(req_data), .req_len_i(req_len),
        .req_pkt_len_i(req_pkt_len), .req_cs_i(req_cs),
        .tx_early_v_o(tx_early_v_o), .tx_ready_v_i(tx_ready_v),
        .tx_cancel_o(tx_cancel_o), .tx_valid_o(tx_valid_o), .tx_last_o(tx_last_o),
        .tx_data_o(tx_data_o), .tx_len_o(tx_len_o),
        .tx_pkt_len_o(tx_pkt_len_o), .tx_cs_o(tx_cs_o),
        .grant_o(grant_o), .busy_o(busy_o), .wdog_err_o(wdog_err_o)
    );

    typedef struct packed {
        logic             last;
        logic [LEN_W-1:0] len;
        logic [DATA_W-1:0] data;
    } beat_t;

    beat_t sb_q[$];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mon();
        beat_t o, e;
        if (tx_valid_o) begin
            o.last = tx_last_o;
            o.len  = tx_len_o;
            o.data = tx_data_o;
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_beat", sb_q.size(), 1);
            end else begin
                e = sb_q.pop_front();
                chk("beat", o, e);
            end
        end
    endtask

    task automatic step();
        #1;
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input int r, input logic lst, input logic [LEN_W-1:0] ln);
        beat_t b;
        b.data = DATA_W'($urandom);
        b.len  = ln;
        b.last = lst;
        req_valid[r] = 1'b1;
        req_last[r]  = lst;
        req_data[r*DATA_W +: DATA_W] = b.data;
        req_len[r*LEN_W +: LEN_W]    = ln;
        sb_q.push_back(b);
    endtask

    task automatic clear_reqs();
        req_early_v = '0;
        req_cancel  = '0;
        req_valid   = '0;
        req_last    = '0;
        tx_ready_v  = 1'b0;
    endtask

    task automatic reset_dut();
        clear_reqs();
        nreset = 1'b0;
        step();
        nreset = 1'b1;
    endtask

    // Both requesters hold early_v; serve one single-beat packet for requester g.
    task automatic serve(input int g);
        #1;
        chk("alt_idle_busy", busy_o, 0);
        step();
        chk("alt_grant", grant_o, g);
        chk("alt_early", tx_early_v_o, 1);
        tx_ready_v = 1'b1;
        #1;
        chk("alt_ready", req_ready_v_o, 1 << g);
        step();
        tx_ready_v = 1'b0;
        drive_beat(g, 1'b1, LEN_W'(2));
        step();
        req_valid[g] = 1'b0;
        req_last[g]  = 1'b0;
        #1;
        chk("alt_gap", {busy_o, tx_valid_o, tx_early_v_o}, 3'b100);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int hits;
        nreset   = 1'b0;
        clear_reqs();
        req_data = '0;
        req_len  = '0;
        req_pkt_len = {16'd40, 16'd19};
        req_cs      = {16'h1234, 16'hBEEF};
        @(posedge clk);
        #1;
        step();
        step();
        nreset = 1'b1;
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_grant", grant_o, 0);
        chk("rst_strobes", {tx_early_v_o, tx_cancel_o, tx_valid_o, tx_last_o, wdog_err_o}, 0);
        chk("rst_ready", req_ready_v_o, 0);
        chk("rst_data", tx_data_o, 0);
        chk("rst_pkt_len", tx_pkt_len_o, 0);

        // single 19-byte packet from requester 0
        req_early_v[0] = 1'b1;
        #1;
        chk("t1_idle_early", tx_early_v_o, 0);
        chk("t1_idle_pkt_len", tx_pkt_len_o, 0);
        step();
        chk("t1_early_lat", tx_early_v_o, 1);
        chk("t1_grant", grant_o, 0);
        chk("t1_pkt_len", tx_pkt_len_o, 19);
        chk("t1_cs", tx_cs_o, 16'hBEEF);
        chk("t1_no_ready", req_ready_v_o, 0);
        step();
        tx_ready_v = 1'b1;
        #1;
        chk("t1_ready", req_ready_v_o, 2'b01);
        step();
        tx_ready_v     = 1'b0;
        req_early_v[0] = 1'b0;
        for (int b = 0; b < 10; b++) begin
            if (b == 4) begin
                req_valid[0] = 1'b0;
                step();
            end
            drive_beat(0, (b == 9), (b == 9) ? LEN_W'(1) : LEN_W'(2));
            step();
        end
        req_valid[0] = 1'b0;
        req_last[0]  = 1'b0;
        #1;
        chk("t1_gap_busy", busy_o, 1);
        chk("t1_gap_valid", tx_valid_o, 0);
        step();
        chk("t1_idle_after", busy_o, 0);
        chk("t1_sb_drained", sb_q.size(), 0);

        // simultaneous requests alternate after reset
        reset_dut();
        req_early_v = 2'b11;
        serve(0);
        serve(1);
        serve(0);
        serve(1);

        // requester 1 cancels on beat 3
        req_early_v = 2'b10;
        step();
        chk("t3_grant", grant_o, 1);
        chk("t3_pkt_len", tx_pkt_len_o, 40);
        tx_ready_v = 1'b1;
        step();
        tx_ready_v  = 1'b0;
        req_early_v = '0;
        for (int b = 0; b < 3; b++) begin
            drive_beat(1, 1'b0, LEN_W'(2));
            #1;
            chk("t3_no_cancel", tx_cancel_o, 0);
            step();
        end
        drive_beat(1, 1'b0, LEN_W'(2));
        req_cancel[1] = 1'b1;
        #1;
        chk("t3_cancel", tx_cancel_o, 1);
        chk("t3_no_wdog", wdog_err_o, 0);
        step();
        req_cancel[1] = 1'b0;
        req_valid[1]  = 1'b0;
        #1;
        chk("t3_gap", {busy_o, tx_cancel_o}, 2'b10);
        step();
        req_early_v = 2'b11;
        #1;
        chk("t3_idle", busy_o, 0);
        step();
        chk("t3_next_grant", grant_o, 0);

        // requester 0 withdraws in HEAD; requester 1 served next
        req_early_v[0] = 1'b0;
        tx_ready_v     = 1'b1;
        #1;
        chk("t5_early_drop", tx_early_v_o, 0);
        chk("t5_no_ready", req_ready_v_o, 0);
        chk("t5_no_cancel", tx_cancel_o, 0);
        step();
        tx_ready_v = 1'b0;
        #1;
        chk("t5_idle", {busy_o, tx_cancel_o}, 2'b00);
        step();
        chk("t5_grant1", grant_o, 1);
        chk("t5_early1", tx_early_v_o, 1);
        tx_ready_v = 1'b1;
        #1;
        chk("t5_ready1", req_ready_v_o, 2'b10);
        step();
        tx_ready_v  = 1'b0;
        req_early_v = '0;
        drive_beat(1, 1'b1, LEN_W'(1));
        step();
        req_valid[1] = 1'b0;
        req_last[1]  = 1'b0;
        step();

        // watchdog: requester 0 stalls in DATA
        req_early_v = 2'b01;
        step();
        chk("t4_grant", grant_o, 0);
        tx_ready_v = 1'b1;
        step();
        tx_ready_v  = 1'b0;
        req_early_v = '0;
        hits = 0;
        for (int k = 1; k < WDOG_MAX; k++) begin
            #1;
            if (tx_cancel_o || wdog_err_o) hits++;
            step();
        end
        #1;
        chk("t4_premature", hits, 0);
        chk("t4_cancel", tx_cancel_o, 1);
        chk("t4_wdog_err", wdog_err_o, 1);
        step();
        chk("t4_gap", {busy_o, tx_cancel_o, wdog_err_o}, 3'b100);
        step();
        chk("t4_idle", busy_o, 0);

        // reset during DATA beat 4 of requester 1
        req_early_v = 2'b10;
        step();
        chk("t6_grant", grant_o, 1);
        tx_ready_v = 1'b1;
        step();
        tx_ready_v  = 1'b0;
        req_early_v = '0;
        for (int b = 0; b < 4; b++) begin
            drive_beat(1, 1'b0, LEN_W'(2));
            step();
        end
        drive_beat(1, 1'b0, LEN_W'(2));
        nreset = 1'b0;
        step();
        nreset       = 1'b1;
        req_valid[1] = 1'b0;
        #1;
        chk("t6_strobes", {tx_early_v_o, tx_cancel_o, tx_valid_o, tx_last_o, wdog_err_o}, 0);
        chk("t6_busy", busy_o, 0);
        chk("t6_grant0", grant_o, 0);
        step();

        chk("sb_final", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
